// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: default widths, EX/WB entry layout, skid buffer
// states and the ALU opcode encodings used by both the ALU and this stage.
package msrv32_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RA_W_DEFAULT = 5;

    // Entry as held by the EX/WB stage at the default widths.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] result;
        logic [RA_W_DEFAULT-1:0] rd_addr;
        logic                    wr_en;
    } entry_t;

    localparam int ENTRY_W_DEFAULT = XLEN_DEFAULT + RA_W_DEFAULT + 1;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // ALU opcodes: bit 3 selects the alternate form (SUB, SRA).
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/msrv32_skid_buf.sv
// Generic two-entry valid/ready skid buffer. MAIN feeds downstream, SKID holds
// the entry accepted while MAIN was stalled; both entries are exposed.
module msrv32_skid_buf
    import msrv32_pkg::*;
#(
    parameter int W = ENTRY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data,
    output logic         main_valid,
    output logic [W-1:0] main_data,
    output logic         skid_valid,
    output logic [W-1:0] skid_data
);

    skid_state_e  state, state_nxt;
    logic         accept, xfer;
    logic         load_main, load_skid, move_skid;
    logic [W-1:0] main_q, skid_q;

    // Ready decodes only the state register, so downstream ready never
    // reaches upstream combinationally.
    assign up_ready   = (state != SKID_FULL);
    assign main_valid = (state != SKID_EMPTY);
    assign skid_valid = (state == SKID_FULL);
    assign dn_valid   = main_valid;
    assign dn_data    = main_q;
    assign main_data  = main_q;
    assign skid_data  = skid_q;

    assign accept = up_valid & up_ready;
    assign xfer   = dn_valid & dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (accept) begin
                    state_nxt = SKID_ONE;
                    load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && xfer) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nxt = SKID_FULL;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (xfer) begin
                    state_nxt = SKID_ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nxt = SKID_EMPTY;
        endcase
        // Flush wins over everything; a transfer this cycle has already
        // happened on the downstream handshake.
        if (flush) begin
            state_nxt = SKID_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
    end

    // Payload registers carry no reset; validity lives entirely in state.
    always_ff @(posedge clk) begin
        if (load_main) begin
            main_q <= up_data;
        end else if (move_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= up_data;
        end
    end

endmodule

// File: rtl/msrv32_ex_wb_stage.sv
// msrv32 execute-to-writeback stage: skid-buffered ALU result with x0 write
// suppression, flush and optional operand forwarding (MSRV32_EXWB_FWD_EN).
module msrv32_ex_wb_stage
    import msrv32_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_n_in,
    input  logic            flush_in,
    input  logic            in_valid_in,
    output logic            in_ready_out,
    input  logic [XLEN-1:0] result_in,
    input  logic [RA_W-1:0] rd_addr_in,
    input  logic            wr_en_in,
    output logic            out_valid_out,
    input  logic            out_ready_in,
    output logic [XLEN-1:0] result_out,
    output logic [RA_W-1:0] rd_addr_out,
    output logic            wr_en_out,
    input  logic [RA_W-1:0] rs1_addr_in,
    input  logic [RA_W-1:0] rs2_addr_in,
    output logic            fwd1_hit_out,
    output logic            fwd2_hit_out,
    output logic [XLEN-1:0] fwd1_data_out,
    output logic [XLEN-1:0] fwd2_data_out
);

    localparam int ENTRY_W = XLEN + RA_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RA_W-1:0] rd_addr;
        logic            wr_en;
    } ex_wb_entry_t;

    ex_wb_entry_t in_entry, out_entry, main_entry, skid_entry;
    logic         out_valid, main_valid, skid_valid;

    always_comb begin
        in_entry.result  = result_in;
        in_entry.rd_addr = rd_addr_in;
        in_entry.wr_en   = wr_en_in & (rd_addr_in != '0);
    end

    msrv32_skid_buf #(
        .W (ENTRY_W)
    ) u_skid_buf (
        .clk        (ms_riscv32_mp_clk_in),
        .rst_n      (ms_riscv32_mp_rst_n_in),
        .flush      (flush_in),
        .up_valid   (in_valid_in),
        .up_ready   (in_ready_out),
        .up_data    (in_entry),
        .dn_valid   (out_valid),
        .dn_ready   (out_ready_in),
        .dn_data    (out_entry),
        .main_valid (main_valid),
        .main_data  (main_entry),
        .skid_valid (skid_valid),
        .skid_data  (skid_entry)
    );

    // Payload is masked by valid so an empty stage reads as all zeros,
    // including straight out of reset and after a flush.
    assign out_valid_out = out_valid;
    assign result_out    = out_valid ? out_entry.result  : '0;
    assign rd_addr_out   = out_valid ? out_entry.rd_addr : '0;
    assign wr_en_out     = out_valid & out_entry.wr_en;

`ifdef MSRV32_EXWB_FWD_EN
    // Returns {hit, data}; SKID is younger than MAIN so it wins on a match.
    function automatic logic [XLEN:0] fwd_lookup(
        input logic [RA_W-1:0] rs,
        input logic            m_valid,
        input ex_wb_entry_t    m_entry,
        input logic            s_valid,
        input ex_wb_entry_t    s_entry
    );
        logic [XLEN:0] r;
        r = '0;
        if (rs != '0) begin
            if (s_valid && s_entry.wr_en && (s_entry.rd_addr == rs)) begin
                r = {1'b1, s_entry.result};
            end else if (m_valid && m_entry.wr_en && (m_entry.rd_addr == rs)) begin
                r = {1'b1, m_entry.result};
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwd1_hit_out, fwd1_data_out} = fwd_lookup(rs1_addr_in, main_valid, main_entry,
                                                   skid_valid, skid_entry);
        {fwd2_hit_out, fwd2_data_out} = fwd_lookup(rs2_addr_in, main_valid, main_entry,
                                                   skid_valid, skid_entry);
    end
`else
    logic unused_fwd;

    assign unused_fwd    = ^{rs1_addr_in, rs2_addr_in, main_valid, main_entry,
                             skid_valid, skid_entry};
    assign fwd1_hit_out  = 1'b0;
    assign fwd2_hit_out  = 1'b0;
    assign fwd1_data_out = '0;
    assign fwd2_data_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_ex_wb_stage.sv
// Directed bench for msrv32_ex_wb_stage: reset, streaming, back-pressure,
// x0 suppression, forwarding priority, flush and asynchronous reset.
module tb_msrv32_ex_wb_stage;

`ifdef MSRV32_EXWB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result_i;
    logic [4:0]  rd_i;
    logic        wr_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        wr_o;
    logic [4:0]  rs1, rs2;
    logic        hit1, hit2;
    logic [31:0] data1, data2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msrv32_ex_wb_stage dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .flush_in               (flush),
        .in_valid_in            (in_valid),
        .in_ready_out           (in_ready),
        .result_in              (result_i),
        .rd_addr_in             (rd_i),
        .wr_en_in               (wr_i),
        .out_valid_out          (out_valid),
        .out_ready_in           (out_ready),
        .result_out             (result_o),
        .rd_addr_out            (rd_o),
        .wr_en_out              (wr_o),
        .rs1_addr_in            (rs1),
        .rs2_addr_in            (rs2),
        .fwd1_hit_out           (hit1),
        .fwd2_hit_out           (hit2),
        .fwd1_data_out          (data1),
        .fwd2_data_out          (data2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd,
                         input logic we, input logic rdy);
        in_valid  = v;
        result_i  = r;
        rd_i      = rd;
        wr_i      = we;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        rs1 = 5'd1;
        rs2 = 5'd0;
        drive(1'b1, 32'h0000_0055, 5'd1, 1'b1, 1'b1);
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_result", result_o, 32'd0);
        check("rst_rd", {27'b0, rd_o}, 32'd0);
        check("rst_wr_en", {31'b0, wr_o}, 32'd0);
        check("rst_fwd1_hit", {31'b0, hit1}, 32'd0);
        check("rst_fwd1_data", data1, 32'd0);

        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick();
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Streaming: each entry visible one edge after its accept.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + i, 5'(i + 1), 1'b1, 1'b1);
            tick();
            check($sformatf("stream%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("stream%0d_result", i), result_o, 32'h10 + i);
            check($sformatf("stream%0d_rd", i), {27'b0, rd_o}, i + 1);
            check($sformatf("stream%0d_ready", i), {31'b0, in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        check("stream_drained", {31'b0, out_valid}, 32'd0);

        // Back-pressure into FULL, then drain in order.
        drive(1'b1, 32'hAAAA_0001, 5'd3, 1'b1, 1'b1);
        tick();
        check("bp_first_result", result_o, 32'hAAAA_0001);
        drive(1'b1, 32'hAAAA_0002, 5'd4, 1'b1, 1'b0);
        tick();
        check("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_full_valid", {31'b0, out_valid}, 32'd1);
        check("bp_full_result", result_o, 32'hAAAA_0001);
        drive(1'b1, 32'h0000_0BAD, 5'd9, 1'b1, 1'b0);
        tick();
        check("bp_hold_result", result_o, 32'hAAAA_0001);
        check("bp_hold_rd", {27'b0, rd_o}, 32'd3);
        check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        check("bp_second_result", result_o, 32'hAAAA_0002);
        check("bp_second_rd", {27'b0, rd_o}, 32'd4);
        check("bp_second_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Write to x0 is suppressed and never forwards.
        drive(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0);
        rs1 = 5'd0;
        tick();
        check("x0_valid", {31'b0, out_valid}, 32'd1);
        check("x0_result", result_o, 32'hDEAD_BEEF);
        check("x0_wr_en", {31'b0, wr_o}, 32'd0);
        check("x0_fwd1_hit", {31'b0, hit1}, 32'd0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();

        // Forwarding: MAIN rd5=0x11, then SKID rd5=0x22 takes priority.
        drive(1'b1, 32'h11, 5'd5, 1'b1, 1'b0);
        rs1 = 5'd6;
        rs2 = 5'd5;
        tick();
        #1;
        check("fwd_main_hit", {31'b0, hit2}, {31'b0, FWD});
        check("fwd_main_data", data2, FWD ? 32'h11 : 32'h0);
        drive(1'b1, 32'h22, 5'd5, 1'b1, 1'b0);
        tick();
        check("fwd_full_in_ready", {31'b0, in_ready}, 32'd0);
        check("fwd_skid_hit", {31'b0, hit2}, {31'b0, FWD});
        check("fwd_skid_data", data2, FWD ? 32'h22 : 32'h0);
        check("fwd_miss_hit", {31'b0, hit1}, 32'd0);
        check("fwd_miss_data", data1, 32'd0);
        rs1 = 5'd5;
        #1;
        check("fwd_rs1_skid_data", data1, FWD ? 32'h22 : 32'h0);

        // Flush from FULL with a simultaneous offered entry.
        drive(1'b1, 32'h99, 5'd7, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_fwd2_hit", {31'b0, hit2}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("flush_no_deliver", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset while an entry is held.
        drive(1'b1, 32'h33, 5'd2, 1'b1, 1'b0);
        tick();
        check("areset_pre_valid", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'b0, out_valid}, 32'd0);
        check("areset_result", result_o, 32'd0);
        check("areset_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        check("areset_stays_empty", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/msrv32_ex_wb_stage.md
# msrv32_ex_wb_stage

Registered execute-to-writeback stage directly downstream of the msrv32 ALU. It captures `result_out` with its destination-register tag and write enable, and holds them in a two-entry skid buffer under a valid/ready handshake. Back-pressure from writeback therefore never drops or duplicates an ALU result. It also offers operand forwarding from held entries to the decode/operand-select logic feeding the ALU.

## Interface
Parameters:
- `XLEN`, 32, data width of the ALU result.
- `RA_W`, 5, register-address width.

Ports:
- `ms_riscv32_mp_clk_in`  in  1  single clock; all state updates on its rising edge.
- `ms_riscv32_mp_rst_n_in`  in  1  asynchronous, active-low reset.
- `flush_in`  in  1  synchronous flush of all held entries.
- `in_valid_in`  in  1  ALU result valid this cycle.
- `in_ready_out`  out  1  stage can accept an entry.
- `result_in`  in  XLEN  ALU `result_out`.
- `rd_addr_in`  in  RA_W  destination register.
- `wr_en_in`  in  1  instruction writes rd.
- `out_valid_out`  out  1  writeback entry valid.
- `out_ready_in`  in  1  writeback accepts.
- `result_out`  out  XLEN  held result.
- `rd_addr_out`  out  RA_W  held destination.
- `wr_en_out`  out  1  held write enable.
- `rs1_addr_in`, `rs2_addr_in`  in  RA_W  operand addresses for forwarding lookup.
- `fwd1_hit_out`, `fwd2_hit_out`  out  1  a held entry matches.
- `fwd1_data_out`, `fwd2_data_out`  out  XLEN  forwarded value.

## Operation
- Two entries:
  - MAIN drives the `*_out` writeback ports.
  - SKID holds the entry accepted while MAIN was stalled.
  - SKID is always younger than MAIN.
- States:
  - EMPTY: MAIN invalid.
  - ONE: MAIN valid, SKID invalid.
  - FULL: both valid.
- Handshakes:
  - Input accepted when `in_valid_in & in_ready_out`.
  - Output transferred when `out_valid_out & out_ready_in`.
- `in_ready_out = ~skid_valid`, taken from a register. There is no combinational path from `out_ready_in`.
- State transitions (A = accept, T = transfer):
  - EMPTY + A → ONE; the entry is loaded into MAIN.
  - ONE + A + T → ONE; MAIN is reloaded with the new entry.
  - ONE + A + ~T → FULL; the entry goes to SKID.
  - ONE + ~A + T → EMPTY.
  - FULL + T → ONE; SKID moves to MAIN. No accept is possible in FULL.
  - All other cases hold state.
- `wr_en` is stored as `wr_en_in & (rd_addr_in != 0)`, so writes to x0 are suppressed at capture.
- Flush:
  - `flush_in` high clears MAIN and SKID valid at the next edge.
  - Flush takes priority over a simultaneous accept; the input entry is dropped.
  - A transfer in the flush cycle still counts as delivered.
- Forwarding lookup:
  - For each rsN, hit requires a valid entry with `wr_en == 1` and `rd_addr == rsN`.
  - SKID takes priority over MAIN.
  - `rsN == 0` never hits.
  - On a miss, data is 0.
- Data/tag registers are not cleared by flush; only valid bits are.

## Timing
- Reset (asynchronous assert, synchronous-release safe):
  - Both valid bits are 0.
  - `out_valid_out = 0`, `in_ready_out = 1`.
  - `result_out = 0`, `rd_addr_out = 0`, `wr_en_out = 0`.
  - Forward hits 0, forward data 0.
- Latency:
  - An entry accepted at edge N appears on `*_out` after edge N (one cycle).
  - Throughput is one entry per cycle while `out_ready_in` stays high.
- `out_valid_out` and the `*_out` payload are stable while `out_valid_out & ~out_ready_in`.
- Forwarding outputs are combinational from held state and `rsN_addr_in`, within the same cycle.
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.

## Configuration
- Macro: `MSRV32_EXWB_FWD_EN`.
- Defined:
  - The forwarding comparators and muxes are compiled in.
  - `fwdN_*` behave as specified above.
- Undefined:
  - The comparators are removed.
  - `fwd1_hit_out`/`fwd2_hit_out` are tied to 0 and `fwd*_data_out` to 0.
  - The ports remain present, so the port list does not change.

## Structure
- Shared package `msrv32_pkg` holds:
  - `XLEN` and `RA_W` defaults.
  - The entry typedef {result, rd_addr, wr_en}.
  - The ALU opcode constants (ADD 4'b0000, SUB 4'b1000, …) shared with the ALU.
- Sub-module `msrv32_skid_buf`:
  - Generic two-entry valid/ready buffer parameterised on payload width.
  - Exposes both entries' valid bits and payload for the forwarding logic.
- The top level adds x0 suppression, flush and forwarding around it.

## Test plan
- Reset: assert `ms_riscv32_mp_rst_n_in` = 0 with `in_valid_in` = 1 → `out_valid_out` = 0, `in_ready_out` = 1, `result_out` = 0.
- Stream: 8 entries, results 0x10..0x17, rd = 1..8, `out_ready_in` held 1 → outputs appear in order, one per cycle, 1-cycle latency.
- Back-pressure:
  - Accept 0xAAAA0001 (rd 3), then drop `out_ready_in` and accept 0xAAAA0002 (rd 4) → FULL, `in_ready_out` = 0, output holds 0xAAAA0001.
  - Raise ready → 0xAAAA0001 then 0xAAAA0002 delivered.
- x0 suppression: `wr_en_in` = 1, rd = 0, result 0xDEADBEEF → `wr_en_out` = 0; `rs1_addr_in` = 0 → `fwd1_hit_out` = 0.
- Forwarding priority: MAIN rd 5 = 0x11, SKID rd 5 = 0x22, `rs2_addr_in` = 5 → `fwd2_hit_out` = 1, data 0x22; with the macro undefined → hit 0, data 0.
- Flush: FULL plus `flush_in` = 1 with `in_valid_in` = 1 → next cycle EMPTY, `out_valid_out` = 0, `in_ready_out` = 1, input entry not delivered.
